stack_alu_sequencer: RTL and testbench

Operand-stack front end that drives the 16-bit combinational ALU from the initiator side. It accepts push/pop/execute commands, pops the top two stack entries onto the ALU's `operand1`/`operand2`/`code` inputs and captures `result`. It then pushes the result back, which forms the register-stack datapath of the CPU. The instruction decoder issues commands, and the ALU is instantiated beside this block.

---
 rtl/stack_alu_pkg.sv | 25 ++
 rtl/operand_stack.sv | 29 ++
 rtl/stack_alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_stack_alu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared command encodings, ALU operation codes and sequencer state type
// for the operand-stack ALU front end.
package stack_alu_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_EXEC = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StExec  = 2'b10,
        StWrite = 2'b11
    } state_e;

endpackage

// File: rtl/operand_stack.sv
// Plain DEPTH x WIDTH register file with one write port and two read ports.
// Index arithmetic lives in the parent, which owns the entry count.
module operand_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr_top,
    input  logic [$clog2(DEPTH)-1:0] i_raddr_sec,
    output logic [WIDTH-1:0]         o_rdata_top,
    output logic [WIDTH-1:0]         o_rdata_sec
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are left uninitialised; the parent's count decides validity.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_top = r_mem[i_raddr_top];
    assign o_rdata_sec = r_mem[i_raddr_sec];

endmodule

// File: rtl/stack_alu_sequencer.sv
// Operand-stack sequencer: accepts PUSH/POP/EXEC, feeds the top two entries to an
// external combinational ALU and writes the result back as a single entry.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [2:0]                 cmd_code,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [WIDTH-1:0]           alu_operand1,
    output logic [WIDTH-1:0]           alu_operand2,
    output logic [2:0]                 alu_code,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e           r_state, w_state_d;
    logic [CW-1:0]    r_count, w_count_d;
    logic             r_err, w_err_d;
    logic [WIDTH-1:0] r_op1, w_op1_d;
    logic [WIDTH-1:0] r_op2, w_op2_d;
    logic [2:0]       r_code, w_code_d;
    logic [WIDTH-1:0] r_result, w_result_d;

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_top_idx, w_sec_idx;
    logic [WIDTH-1:0] w_top_data, w_sec_data;

    assign w_top_idx = AW'(r_count - CW'(1));
    assign w_sec_idx = AW'(r_count - CW'(2));

    operand_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_stack (
        .i_clk       (clk),
        .i_we        (w_we && !rst),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_raddr_top (w_top_idx),
        .i_raddr_sec (w_sec_idx),
        .o_rdata_top (w_top_data),
        .o_rdata_sec (w_sec_data)
    );

    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_err_d    = 1'b0;
        w_op1_d    = r_op1;
        w_op2_d    = r_op2;
        w_code_d   = r_code;
        w_result_d = r_result;
        w_we       = 1'b0;
        w_waddr    = AW'(r_count);
        w_wdata    = cmd_data;

        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_PUSH: begin
                            if (r_count < DEPTH_C) begin
                                w_we      = 1'b1;
                                w_count_d = r_count + CW'(1);
                            end else begin
                                w_err_d = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (r_count != '0) begin
                                w_count_d = r_count - CW'(1);
                            end else begin
                                w_err_d = 1'b1;
                            end
                        end
                        OP_EXEC: begin
                            if (r_count >= CW'(2)) begin
                                w_code_d  = cmd_code;
                                w_op1_d   = w_sec_data;
                                w_op2_d   = w_top_data;
                                w_state_d = StLoad;
                            end else begin
                                w_err_d = 1'b1;
                            end
                        end
                        OP_NOP: begin
                        end
                    endcase
                end
            end
            StLoad: w_state_d = StExec;
            StExec: begin
                w_result_d = alu_result;
                w_state_d  = StWrite;
            end
            // Overwrite the lower operand slot; dropping count by one discards the upper.
            StWrite: begin
                w_we      = 1'b1;
                w_waddr   = w_sec_idx;
                w_wdata   = r_result;
                w_count_d = r_count - CW'(1);
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_code   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_count  <= w_count_d;
            r_err    <= w_err_d;
            r_op1    <= w_op1_d;
            r_op2    <= w_op2_d;
            r_code   <= w_code_d;
            r_result <= w_result_d;
        end
    end

    assign cmd_ready    = (r_state == StIdle);
    assign alu_operand1 = r_op1;
    assign alu_operand2 = r_op2;
    assign alu_code     = r_code;
    assign top          = (r_count == '0) ? '0 : w_top_data;
    assign count        = r_count;
    assign err          = r_err;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural 16-bit ALU beside it.
module tb_stack_alu_sequencer;
    import stack_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_code;
    logic [15:0] cmd_data;
    logic [15:0] alu_operand1;
    logic [15:0] alu_operand2;
    logic [2:0]  alu_code;
    logic [15:0] alu_result;
    logic [15:0] top;
    logic [3:0]  count;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stack_alu_sequencer #(
        .DEPTH (8),
        .WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_code     (cmd_code),
        .cmd_data     (cmd_data),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_code     (alu_code),
        .alu_result   (alu_result),
        .top          (top),
        .count        (count),
        .err          (err)
    );

    always_comb begin
        alu_result = 16'h0000;
        case (alu_code)
            ALU_ADD: alu_result = alu_operand1 + alu_operand2;
            ALU_SUB: alu_result = alu_operand1 - alu_operand2;
            ALU_AND: alu_result = alu_operand1 & alu_operand2;
            ALU_OR:  alu_result = alu_operand1 | alu_operand2;
            ALU_XOR: alu_result = alu_operand1 ^ alu_operand2;
            ALU_SHL: alu_result = alu_operand1 << alu_operand2;
            ALU_SHR: alu_result = alu_operand1 >> alu_operand2;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] code, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_code  = code;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic push(input logic [15:0] data);
        issue(OP_PUSH, 3'b000, data);
    endtask

    task automatic pop();
        issue(OP_POP, 3'b000, 16'h0000);
    endtask

    task automatic exec_full(input logic [2:0] code);
        issue(OP_EXEC, code, 16'h0000);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_code  = 3'b000;
        cmd_data  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_top", 32'(top), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op1", 32'(alu_operand1), 32'd0);
        check("rst_op2", 32'(alu_operand2), 32'd0);
        check("rst_code", 32'(alu_code), 32'd0);

        // 5 - 3
        push(16'd5);
        push(16'd3);
        check("push_count", 32'(count), 32'd2);
        check("push_top", 32'(top), 32'd3);
        issue(OP_EXEC, ALU_SUB, 16'h0000);
        check("sub_op1", 32'(alu_operand1), 32'd5);
        check("sub_op2", 32'(alu_operand2), 32'd3);
        check("sub_code", 32'(alu_code), 32'(ALU_SUB));
        check("sub_busy", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("sub_busy2", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("sub_top", 32'(top), 32'd2);
        check("sub_count", 32'(count), 32'd1);
        check("sub_err", 32'(err), 32'd0);
        check("sub_ready", 32'(cmd_ready), 32'd1);
        pop();

        // 1 << 20 overflows to zero; 0xFFFF + 1 wraps
        push(16'h0001);
        push(16'd20);
        exec_full(ALU_SHL);
        check("shl_top", 32'(top), 32'h0000);
        check("shl_count", 32'(count), 32'd1);
        pop();
        push(16'hFFFF);
        push(16'h0001);
        exec_full(ALU_ADD);
        check("wrap_top", 32'(top), 32'h0000);
        check("wrap_count", 32'(count), 32'd1);
        pop();

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
        end
        check("full_count", 32'(count), 32'd8);
        check("full_top", 32'(top), 32'd8);
        push(16'hAAAA);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_top", 32'(top), 32'd8);
        issue(OP_NOP, 3'b000, 16'h0000);
        check("ovf_err_drop", 32'(err), 32'd0);
        exec_full(ALU_XOR);
        check("xor_count", 32'(count), 32'd7);
        check("xor_top", 32'(top), 32'h000F);
        for (int i = 0; i < 7; i++) begin
            pop();
        end
        check("drain_count", 32'(count), 32'd0);

        // Underflow cases
        pop();
        check("unf_err", 32'(err), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("unf_top", 32'(top), 32'd0);
        push(16'd7);
        check("unf_err_drop", 32'(err), 32'd0);
        issue(OP_EXEC, ALU_ADD, 16'h0000);
        check("exec1_err", 32'(err), 32'd1);
        check("exec1_ready", 32'(cmd_ready), 32'd1);
        check("exec1_count", 32'(count), 32'd1);
        check("exec1_top", 32'(top), 32'd7);
        pop();

        // Reset during the EXEC state aborts the writeback
        push(16'h00F0);
        push(16'h0F0F);
        issue(OP_EXEC, ALU_OR, 16'h0000);
        check("abort_op1", 32'(alu_operand1), 32'h00F0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_count", 32'(count), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_op1_clr", 32'(alu_operand1), 32'd0);
        check("abort_op2_clr", 32'(alu_operand2), 32'd0);
        check("abort_code_clr", 32'(alu_code), 32'd0);
        check("abort_top", 32'(top), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_wb", 32'(count), 32'd0);

        // Back-to-back pushes with cmd_valid held
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        for (int i = 1; i <= 3; i++) begin
            cmd_data = 16'(i);
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        check("b2b_count", 32'(count), 32'd3);
        check("b2b_top", 32'(top), 32'd3);
        exec_full(ALU_ADD);
        check("b2b_add1", 32'(top), 32'd5);
        issue(OP_EXEC, ALU_ADD, 16'h0000);
        check("b2b_op1", 32'(alu_operand1), 32'd1);
        check("b2b_op2", 32'(alu_operand2), 32'd5);
        repeat (3) @(negedge clk);
        check("b2b_top", 32'(top), 32'd6);
        check("b2b_count_end", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
